// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl -- March C- style self-test master for a single-port
// synchronous RAM with a registered read port (1-cycle read latency, read
// register holds while we=1).
//
// Sequence after an accepted start pulse (one command per clock):
//   M0 : ascending,  write BG
//   M1 : ascending,  read (expect BG),  write ~BG
//   M2 : descending, read (expect ~BG), write BG
//   M3 : ascending,  read (expect BG)
//   DRAIN : no command, last compare completes; then DONE.
//
// Optional feature: define BIST_STOP_ON_FAIL_EN to end the test at the first
// mismatching compare (the in-flight command is dropped).
//
// Ports:
//   clk        rising-edge clock, shared with the RAM
//   rst_n      synchronous active-low reset
//   start      one-cycle request, honoured only in IDLE/DONE
//   mem_we     RAM write enable
//   mem_addr   RAM address
//   mem_din    RAM write data (0 on reads)
//   mem_dout   RAM registered read data
//   busy       test in progress
//   done       test complete, held until the next accepted start
//   fail       sticky mismatch flag
//   fail_addr  address of the first mismatch
//   fail_data  data read at the first mismatch
//   err_count  mismatch count, saturating at 255
module ram_bist_ctrl #(
  parameter int                 ADDR_W     = 6,
  parameter int                 DATA_W     = 8,
  parameter logic [DATA_W-1:0]  BG_PATTERN = 8'h55
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [7:0]        err_count
);

  typedef enum logic [3:0] {
    IDLE, M0, M1_R, M1_W, M2_R, M2_W, M3_R, DRAIN, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  // state_reg/addr_reg describe the command currently driven on the RAM port.
  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                we_reg, we_next;
  logic [DATA_W-1:0]   din_reg, din_next;
  // Expected-value pipeline stage: loaded when the RAM samples a read command,
  // compared one edge later when the RAM out register holds the result.
  logic                exp_valid_reg, exp_valid_next;
  logic [DATA_W-1:0]   exp_data_reg, exp_data_next;
  logic [ADDR_W-1:0]   exp_addr_reg, exp_addr_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                fail_reg, fail_next;
  logic [ADDR_W-1:0]   fail_addr_reg, fail_addr_next;
  logic [DATA_W-1:0]   fail_data_reg, fail_data_next;
  logic [7:0]          err_reg, err_next;
  logic                mismatch;

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    fail_next      = fail_reg;
    fail_addr_next = fail_addr_reg;
    fail_data_next = fail_data_reg;
    err_next       = err_reg;

    exp_valid_next = (state_reg == M1_R) || (state_reg == M2_R) || (state_reg == M3_R);
    exp_data_next  = (state_reg == M2_R) ? ~BG_PATTERN : BG_PATTERN;
    exp_addr_next  = addr_reg;

    mismatch = exp_valid_reg && (mem_dout != exp_data_reg);
    if (mismatch) begin
      fail_next = 1'b1;
      if (!fail_reg) begin
        fail_addr_next = exp_addr_reg;
        fail_data_next = mem_dout;
      end
      if (err_reg != 8'hFF) err_next = err_reg + 8'd1;
    end

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next     = M0;
          addr_next      = '0;
          exp_valid_next = 1'b0;
          fail_next      = 1'b0;
          fail_addr_next = '0;
          fail_data_next = '0;
          err_next       = 8'd0;
        end
      end
      M0: begin
        if (addr_reg == ADDR_LAST) begin
          state_next = M1_R;
          addr_next  = '0;
        end else begin
          addr_next  = addr_reg + 1'b1;
        end
      end
      M1_R: state_next = M1_W;
      M1_W: begin
        // M2 starts at the top address: no wrap back to 0.
        if (addr_reg == ADDR_LAST) begin
          state_next = M2_R;
        end else begin
          state_next = M1_R;
          addr_next  = addr_reg + 1'b1;
        end
      end
      M2_R: state_next = M2_W;
      M2_W: begin
        if (addr_reg == '0) begin
          state_next = M3_R;
        end else begin
          state_next = M2_R;
          addr_next  = addr_reg - 1'b1;
        end
      end
      M3_R: begin
        if (addr_reg == ADDR_LAST) begin
          state_next = DRAIN;
          addr_next  = '0;
        end else begin
          addr_next  = addr_reg + 1'b1;
        end
      end
      DRAIN:   state_next = DONE;
      default: state_next = IDLE;
    endcase

`ifdef BIST_STOP_ON_FAIL_EN
    if (mismatch) begin
      state_next     = DONE;
      addr_next      = '0;
      exp_valid_next = 1'b0;
    end
`endif

    // Port values are decoded from the state being entered so they leave
    // the flops together with the state.
    busy_next = (state_next != IDLE) && (state_next != DONE);
    done_next = (state_next == DONE);
    we_next   = (state_next == M0) || (state_next == M1_W) || (state_next == M2_W);
    case (state_next)
      M0, M2_W: din_next = BG_PATTERN;
      M1_W:     din_next = ~BG_PATTERN;
      default:  din_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      din_reg       <= '0;
      exp_valid_reg <= 1'b0;
      exp_data_reg  <= '0;
      exp_addr_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      fail_reg      <= 1'b0;
      fail_addr_reg <= '0;
      fail_data_reg <= '0;
      err_reg       <= 8'd0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      we_reg        <= we_next;
      din_reg       <= din_next;
      exp_valid_reg <= exp_valid_next;
      exp_data_reg  <= exp_data_next;
      exp_addr_reg  <= exp_addr_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      fail_reg      <= fail_next;
      fail_addr_reg <= fail_addr_next;
      fail_data_reg <= fail_data_next;
      err_reg       <= err_next;
    end
  end

  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_din   = din_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign fail      = fail_reg;
  assign fail_addr = fail_addr_reg;
  assign fail_data = fail_data_reg;
  assign err_count = err_reg;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Testbench for ram_bist_ctrl: a 64x8 registered-read RAM model with
// per-address stuck-at masks, and a march reference model that replays the
// algorithm on a plain array to predict commands, results and done timing.
module tb_ram_bist_ctrl;
  localparam int         DEPTH = 64;
  localparam int         NCMD  = 384;
  localparam logic [7:0] BG    = 8'h55;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mem_we;
  logic [5:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic       busy, done, fail;
  logic [5:0] fail_addr;
  logic [7:0] fail_data;
  logic [7:0] err_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram_bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_data(fail_data), .err_count(err_count)
  );

  // RAM model: stuck-at faults are applied to the stored value.
  logic [7:0] mem   [DEPTH];
  logic [7:0] and_m [DEPTH];
  logic [7:0] or_m  [DEPTH];
  logic [7:0] ram_out = 8'h00;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= (mem_din & and_m[mem_addr]) | or_m[mem_addr];
    else        ram_out <= mem[mem_addr];
  end
  assign mem_dout = ram_out;

  // Reference model results
  int         m_we   [NCMD];
  int         m_addr [NCMD];
  logic [7:0] m_din  [NCMD];
  logic [7:0] m_rexp [NCMD];
  logic [7:0] m_final[DEPTH];
  int         m_done_edge, m_err, m_first_addr;
  logic [7:0] m_first_data;
  bit         m_fail;

  // Observed trace
  int obs_we [600];
  int obs_addr[600];
  int obs_din [600];
  int obs_busy[600];
  int obs_len, done_edge;

  task automatic set_no_faults();
    for (int a = 0; a < DEPTH; a++) begin
      and_m[a] = 8'hFF;
      or_m[a]  = 8'h00;
    end
  endtask

  task automatic push(inout int n, input int we, input int a, input logic [7:0] d, input logic [7:0] e);
    m_we[n] = we; m_addr[n] = a; m_din[n] = d; m_rexp[n] = e; n++;
  endtask

  task automatic build_model();
    logic [7:0] m [DEPTH];
    int n, first_cmd, errs;
    n = 0;
    for (int a = 0; a < DEPTH; a++) push(n, 1, a, BG, 8'h00);
    for (int a = 0; a < DEPTH; a++) begin push(n, 0, a, 8'h00, BG);  push(n, 1, a, ~BG, 8'h00); end
    for (int a = DEPTH-1; a >= 0; a--) begin push(n, 0, a, 8'h00, ~BG); push(n, 1, a, BG, 8'h00); end
    for (int a = 0; a < DEPTH; a++) push(n, 0, a, 8'h00, BG);
    first_cmd = -1; errs = 0;
    m_first_addr = 0; m_first_data = 8'h00;
    for (int i = 0; i < NCMD; i++) begin
      if (m_we[i] == 1) begin
        m[m_addr[i]] = (m_din[i] & and_m[m_addr[i]]) | or_m[m_addr[i]];
      end else if (m[m_addr[i]] !== m_rexp[i]) begin
        if (first_cmd < 0) begin
          first_cmd = i; m_first_addr = m_addr[i]; m_first_data = m[m_addr[i]];
        end
        errs++;
      end
    end
    m_fail = (first_cmd >= 0);
    m_err = (errs > 255) ? 255 : errs;
    m_done_edge = NCMD + 1;
`ifdef BIST_STOP_ON_FAIL_EN
    if (m_fail) begin
      m_done_edge = first_cmd + 2;
      m_err = 1;
    end
`endif
    for (int a = 0; a < DEPTH; a++) m_final[a] = m[a];
  endtask

  // Pulse start, then sample once per edge (#1 after it) until done.
  task automatic run(input int p1, input int p2, input int stop_at);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    done_edge = -1; obs_len = 0;
    for (int k = 0; k < 600; k++) begin
      obs_we[k] = int'(mem_we); obs_addr[k] = int'(mem_addr);
      obs_din[k] = int'(mem_din); obs_busy[k] = int'(busy);
      obs_len = k + 1;
      if (done) begin done_edge = k; break; end
      if (k == stop_at) break;
      if (k == p1 || k == p2) start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
  endtask

  // Full march run with the current fault set, checked against the model.
  task automatic test_march(input string tag, input int p1, input int p2);
    int exp_we, bad;
    bit check_ram;
    build_model();
    run(p1, p2, -1);
    vectors++;
    if (done_edge !== m_done_edge) begin
      miscompares++;
      $display("FAIL %s done_edge: got %0d expected %0d", tag, done_edge, m_done_edge);
    end
    for (int k = 0; k < m_done_edge && k < obs_len; k++) begin
      exp_we = (k < NCMD) ? m_we[k] : 0;
      vectors++;
      if (obs_we[k] !== exp_we || obs_busy[k] !== 1 ||
          (k < NCMD && (obs_addr[k] !== m_addr[k] || obs_din[k] !== int'(m_din[k])))) begin
        miscompares++;
        $display("FAIL %s cmd[%0d]: got we=%0d addr=%0d din=%02h busy=%0d expected we=%0d addr=%0d din=%02h busy=1",
                 tag, k, obs_we[k], obs_addr[k], obs_din[k], obs_busy[k], exp_we,
                 (k < NCMD) ? m_addr[k] : 0, (k < NCMD) ? m_din[k] : 8'h00);
      end
    end
    vectors++;
    if (busy !== 1'b0 || fail !== m_fail || err_count !== 8'(m_err) ||
        fail_addr !== 6'(m_first_addr) || fail_data !== m_first_data) begin
      miscompares++;
      $display("FAIL %s result: got busy=%0b fail=%0b err=%0d addr=%0d data=%02h expected busy=0 fail=%0b err=%0d addr=%0d data=%02h",
               tag, busy, fail, err_count, fail_addr, fail_data, m_fail, m_err, m_first_addr, m_first_data);
    end
    check_ram = 1'b1;
`ifdef BIST_STOP_ON_FAIL_EN
    check_ram = !m_fail;
`endif
    if (check_ram) begin
      bad = 0;
      for (int a = 0; a < DEPTH; a++) if (mem[a] !== m_final[a]) bad++;
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL %s ram_content: got %0d differing addresses expected 0", tag, bad);
      end
    end
    $display("run %s: done_edge=%0d fail=%0b err=%0d fail_addr=%0d fail_data=%02h",
             tag, done_edge, fail, err_count, fail_addr, fail_data);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({mem_we, mem_addr, mem_din, busy, done, fail, fail_addr, fail_data, err_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got we=%0b addr=%0d din=%02h busy=%0b done=%0b fail=%0b expected all 0",
               mem_we, mem_addr, mem_din, busy, done, fail);
    end
    start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%0b we=%0b expected 0 0", busy, mem_we);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_clean();
    set_no_faults();
    test_march("clean", -1, -1);
    vectors++;
    if (done_edge !== 385 || fail !== 1'b0 || err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL clean_spec: got done_edge=%0d fail=%0b err=%0d expected 385 0 0", done_edge, fail, err_count);
    end
  endtask

  task automatic test_stuck17();
    set_no_faults();
    and_m[17] = 8'hF7;
    test_march("stuck0_bit3_a17", -1, -1);
    vectors++;
    if (fail !== 1'b1 || fail_addr !== 6'd17 || fail_data !== 8'hA2 || err_count !== 8'd1) begin
      miscompares++;
      $display("FAIL stuck17_spec: got fail=%0b addr=%0d data=%02h err=%0d expected 1 17 a2 1",
               fail, fail_addr, fail_data, err_count);
    end
  endtask

  task automatic test_stuck_bit0();
    set_no_faults();
    for (int a = 0; a < DEPTH; a++) and_m[a] = 8'hFE;
    test_march("stuck0_bit0_all", -1, -1);
    vectors++;
`ifdef BIST_STOP_ON_FAIL_EN
    if (done_edge !== 66 || err_count !== 8'd1 || fail_addr !== 6'd0) begin
      miscompares++;
      $display("FAIL bit0_spec: got done_edge=%0d err=%0d addr=%0d expected 66 1 0", done_edge, err_count, fail_addr);
    end
`else
    if (err_count !== 8'd128 || fail_addr !== 6'd0) begin
      miscompares++;
      $display("FAIL bit0_spec: got err=%0d addr=%0d expected 128 0", err_count, fail_addr);
    end
`endif
  endtask

  task automatic test_random_faults();
    int a, b;
    for (int it = 0; it < 4; it++) begin
      set_no_faults();
      for (int f = 0; f <= it; f++) begin
        a = $urandom_range(0, DEPTH-1);
        b = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1) and_m[a][b] = 1'b0;
        else                          or_m[a][b]  = 1'b1;
      end
      test_march($sformatf("random%0d", it), int'($urandom_range(1, 380)), -1);
    end
  endtask

  task automatic test_start_ignored();
    set_no_faults();
    test_march("start_while_busy", 10, 200);
  endtask

  task automatic test_mid_reset();
    set_no_faults();
    build_model();
    run(-1, -1, 100);
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({mem_we, mem_addr, mem_din, busy, done, fail, fail_addr, fail_data, err_count} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got we=%0b addr=%0d din=%02h busy=%0b done=%0b expected all 0",
               mem_we, mem_addr, mem_din, busy, done);
    end
    rst_n = 1'b1;
    test_march("after_reset", -1, -1);
  endtask

  task automatic test_back_to_back();
    int cnt;
    set_no_faults();
    for (int a = 0; a < DEPTH; a++) and_m[a] = 8'hFE;
    test_march("pre_restart", -1, -1);
    set_no_faults();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    vectors++;
    if (done !== 1'b0 || fail !== 1'b0 || err_count !== 8'd0 || busy !== 1'b1 ||
        fail_addr !== 6'd0 || fail_data !== 8'h00) begin
      miscompares++;
      $display("FAIL restart_clear: got done=%0b fail=%0b err=%0d busy=%0b addr=%0d data=%02h expected 0 0 0 1 0 00",
               done, fail, err_count, busy, fail_addr, fail_data);
    end
    cnt = 0;
    while (!done && cnt < 500) begin
      @(posedge clk); #1; cnt++;
    end
    vectors++;
    if (cnt !== 385 || fail !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_done: got %0d edges fail=%0b expected 385 edges fail=0", cnt, fail);
    end
    $display("run restart: done after %0d edges fail=%0b err=%0d", cnt, fail, err_count);
  endtask

  initial begin
    set_no_faults();
    test_reset();
    test_clean();
    test_stuck17();
    test_stuck_bit0();
    test_random_faults();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
